// File: rtl/demux_tx_scheduler_pkg.sv
// Shared types and sizing helpers for the demux transmit scheduler and its shifter.
package demux_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = $clog2(NUM_CH);
  localparam int GAP_W  = 4;

  // Bit-counter width; never below 1 so the counter always exists.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/demux_tx_scheduler_piso.sv
// Parallel-in serial-out shifter: loads a word, shifts it out MSB-first and
// flags the cycle on which its last bit is at the MSB.
module piso_shifter
  import demux_tx_scheduler_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] load_data,
  output logic              msb,
  output logic              last
);

  localparam int CNT_W = clog2(DATA_W);

  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      data_q <= load_data;
      cnt_q  <= CNT_W'(DATA_W - 1);
    end else if (shift) begin
      data_q <= {data_q[DATA_W-2:0], 1'b0};
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign msb  = data_q[DATA_W-1];
  assign last = (cnt_q == '0);

endmodule

// File: rtl/demux_tx_scheduler.sv
// Feeds (byte, channel) words to the 1-to-4 serial demux: one frame per word,
// select held for the frame, optional idle gap, one-entry hold register.
module demux_tx_scheduler
  import demux_tx_scheduler_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_chan,
  output logic              ser_bit,
  output logic [SEL_W-1:0]  ser_sel,
  output logic              ser_en,
  output logic              frame_done
);

  localparam logic [GAP_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  state_t             state_q, state_d;
  logic               hold_valid;
  logic [DATA_W-1:0]  hold_data;
  logic [SEL_W-1:0]   hold_chan;
  logic [SEL_W-1:0]   sel_q;
  logic [GAP_W-1:0]   gap_cnt;
  logic               xfer, hold_wr;
  logic               load, from_hold, shift, gap_start;
  logic               msb, last;
  logic [DATA_W-1:0]  load_data;

  // Ready comes straight from the hold flag: no path from in_valid.
  assign in_ready  = !hold_valid;
  assign xfer      = in_valid && in_ready;
  assign hold_wr   = xfer && (state_q != IDLE);
  assign load_data = from_hold ? hold_data : in_data;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    from_hold = 1'b0;
    shift     = 1'b0;
    gap_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hold_valid) begin
          load      = 1'b1;
          from_hold = 1'b1;
          state_d   = SHIFT;
        end else if (xfer) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (last) begin
          if (GAP_CYCLES > 0) begin
            gap_start = 1'b1;
            state_d   = GAP;
          end else if (hold_valid) begin
            load      = 1'b1;
            from_hold = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          if (hold_valid) begin
            load      = 1'b1;
            from_hold = 1'b1;
            state_d   = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_valid <= 1'b0;
      sel_q      <= '0;
      gap_cnt    <= '0;
    end else begin
      state_q <= state_d;
      if (load) sel_q <= from_hold ? hold_chan : in_chan;
      if (load && from_hold) hold_valid <= 1'b0;
      else if (hold_wr)      hold_valid <= 1'b1;
      if (gap_start) gap_cnt <= GAP_LOAD;
      else if (state_q == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // NOTE: the hold payload is qualified by hold_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (hold_wr) begin
      hold_data <= in_data;
      hold_chan <= in_chan;
    end
  end

  piso_shifter #(.DATA_W(DATA_W)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .shift     (shift),
    .load_data (load_data),
    .msb       (msb),
    .last      (last)
  );

  // Decoded only from flops; the serial bit is forced low outside a frame.
  assign ser_en     = (state_q == SHIFT);
  assign ser_bit    = ser_en && msb;
  assign frame_done = ser_en && last;
  assign ser_sel    = sel_q;

endmodule

// File: tb/tb_demux_tx_scheduler.sv
// Bench for demux_tx_scheduler: GAP_CYCLES=0 and GAP_CYCLES=1 instances checked
// cycle by cycle against a frame-schedule model, plus directed scenarios.
module tb_demux_tx_scheduler;

  localparam int DW   = 8;
  localparam int MAXC = 1200;

  typedef struct packed {
    logic       rdy;
    logic       en;
    logic       bt;
    logic       done;
    logic [1:0] sel;
  } obs_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    chan;
    int            delay;
  } word_t;

  logic clk = 1'b0;
  logic rst;
  logic v0, v1, r0, r1, b0, b1, e0, e1, f0, f1;
  logic [DW-1:0] d0, d1;
  logic [1:0] c0, c1, s0, s1;

  int n_checks = 0;
  int n_pass   = 0;
  obs_t  exp_a [MAXC];
  obs_t  obs_a [MAXC];
  word_t offer_q [$];
  logic [1:0] model_sel [2];
  int prev_free;
  int n_accepted;

  always #5 clk = ~clk;

  demux_tx_scheduler #(.DATA_W(DW), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_data(d0),
    .in_chan(c0), .ser_bit(b0), .ser_sel(s0), .ser_en(e0), .frame_done(f0)
  );

  demux_tx_scheduler #(.DATA_W(DW), .GAP_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(d1),
    .in_chan(c1), .ser_bit(b1), .ser_sel(s1), .ser_en(e1), .frame_done(f1)
  );

  task automatic sample(input int k, output obs_t o);
    if (k == 0) o = {r0, e0, b0, f0, s0};
    else        o = {r1, e1, b1, f1, s1};
  endtask

  task automatic drive(input int k, input logic v, input logic [DW-1:0] d, input logic [1:0] c);
    if (k == 0) begin v0 = v; d0 = d; c0 = c; end
    else        begin v1 = v; d1 = d; c1 = c; end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_sel[0] = 2'd0;
    model_sel[1] = 2'd0;
  endtask

  // Schedule of a word accepted at edge a: it starts as soon as the previous
  // frame plus its gap is over; a word taken on that very edge lands in the
  // hold register and costs one extra idle cycle.
  task automatic model_accept(input int k, input int a, input word_t w, input int gap);
    int s;
    if (a < prev_free)       s = prev_free + 1;
    else if (a == prev_free) s = a + 2;
    else                     s = a + 1;
    for (int c = a + 1; c < s && c < MAXC; c++) exp_a[c].rdy = 1'b0;
    for (int i = 0; i < DW; i++) begin
      if (s + i < MAXC) begin
        exp_a[s+i].en   = 1'b1;
        exp_a[s+i].bt   = w.data[DW-1-i];
        exp_a[s+i].done = (i == DW - 1);
      end
    end
    for (int c = s; c < MAXC; c++) exp_a[c].sel = w.chan;
    model_sel[k] = w.chan;
    prev_free    = s + DW - 1 + gap;
    n_accepted++;
  endtask

  // Offers the words in offer_q (each after its delay, held until accepted)
  // and compares every cycle against the model; records observations.
  task automatic run_stream(input int k, input int ncyc);
    int    gap;
    bit    pending;
    word_t cur;
    word_t head;
    obs_t  o;
    gap = (k == 0) ? 0 : 1;
    for (int c = 0; c < MAXC; c++)
      exp_a[c] = '{rdy: 1'b1, en: 1'b0, bt: 1'b0, done: 1'b0, sel: model_sel[k]};
    prev_free  = -100;
    pending    = 1'b0;
    n_accepted = 0;
    cur        = '{data: '0, chan: '0, delay: 0};
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      sample(k, o);
      obs_a[c] = o;
      n_checks++;
      if (o !== exp_a[c])
        $display("FAIL stream dut%0d cycle %0d: rdy/en/bit/done/sel got %b want %b", k, c, o, exp_a[c]);
      else n_pass++;
      if (!pending && offer_q.size() > 0) begin
        head = offer_q[0];
        if (head.delay == 0) begin
          cur     = offer_q.pop_front();
          pending = 1'b1;
        end else begin
          head.delay--;
          offer_q[0] = head;
        end
      end
      if (pending) drive(k, 1'b1, cur.data, cur.chan);
      else         drive(k, 1'b0, DW'($urandom), 2'($urandom));
      if (pending && o.rdy) begin
        model_accept(k, c, cur, gap);
        pending = 1'b0;
      end
    end
    drive(k, 1'b0, '0, '0);
  endtask

  task automatic test_reset;
    obs_t o;
    obs_t want;
    want = '{rdy: 1'b1, en: 1'b0, bt: 1'b0, done: 1'b0, sel: 2'd0};
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sample(k, o);
      n_checks++;
      if (o !== want) $display("FAIL reset_state dut%0d: got %b want %b", k, o, want);
      else n_pass++;
    end
  endtask

  task automatic test_idle;
    run_stream(1, 20);
    run_stream(0, 20);
  endtask

  task automatic test_single_frame;
    logic [DW-1:0] pat;
    pat = 8'hA5;
    do_reset();
    offer_q.push_back('{data: 8'hA5, chan: 2'd2, delay: 0});
    run_stream(1, 14);
    for (int c = 1; c <= 8; c++) begin
      n_checks++;
      if (obs_a[c].en !== 1'b1 || obs_a[c].sel !== 2'd2 || obs_a[c].bt !== pat[DW-c]
          || obs_a[c].done !== (c == 8))
        $display("FAIL single_frame cycle %0d: en/bit/done/sel got %b want en=1 bit=%b done=%0d sel=2",
                 c, obs_a[c], pat[DW-c], (c == 8));
      else n_pass++;
    end
    n_checks++;
    if (obs_a[9].en !== 1'b0 || obs_a[9].bt !== 1'b0 || obs_a[10].en !== 1'b0)
      $display("FAIL single_frame_gap: cycle9 %b cycle10 %b want en=0 bit=0", obs_a[9], obs_a[10]);
    else n_pass++;
  endtask

  task automatic test_hold;
    logic [DW-1:0] pat;
    pat = 8'h5A;
    do_reset();
    offer_q.push_back('{data: 8'h3C, chan: 2'd1, delay: 0});
    offer_q.push_back('{data: 8'hFF, chan: 2'd3, delay: 0});
    offer_q.push_back('{data: 8'h5A, chan: 2'd0, delay: 0});
    run_stream(1, 32);
    for (int c = 2; c <= 9; c++) begin
      n_checks++;
      if (obs_a[c].rdy !== 1'b0) $display("FAIL hold_ready cycle %0d: got %b want 0", c, obs_a[c].rdy);
      else n_pass++;
    end
    n_checks++;
    if (obs_a[9].en !== 1'b0 || obs_a[10].rdy !== 1'b1)
      $display("FAIL hold_gap: cycle9 en=%b cycle10 rdy=%b want 0 and 1", obs_a[9].en, obs_a[10].rdy);
    else n_pass++;
    for (int c = 10; c <= 17; c++) begin
      n_checks++;
      if (obs_a[c].en !== 1'b1 || obs_a[c].sel !== 2'd3 || obs_a[c].bt !== 1'b1)
        $display("FAIL held_frame cycle %0d: got %b want en=1 bit=1 sel=3", c, obs_a[c]);
      else n_pass++;
    end
    for (int c = 19; c <= 26; c++) begin
      n_checks++;
      if (obs_a[c].en !== 1'b1 || obs_a[c].sel !== 2'd0 || obs_a[c].bt !== pat[26-c])
        $display("FAIL third_word cycle %0d: got %b want en=1 bit=%b sel=0", c, obs_a[c], pat[26-c]);
      else n_pass++;
    end
    n_checks++;
    if (n_accepted !== 3) $display("FAIL hold_accepted: got %0d want 3", n_accepted);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [2*DW-1:0] pat;
    logic [1:0] want_sel;
    pat = 16'h817E;
    do_reset();
    offer_q.push_back('{data: 8'h81, chan: 2'd0, delay: 0});
    offer_q.push_back('{data: 8'h7E, chan: 2'd2, delay: 0});
    run_stream(0, 20);
    for (int c = 1; c <= 16; c++) begin
      want_sel = (c <= 8) ? 2'd0 : 2'd2;
      n_checks++;
      if (obs_a[c].en !== 1'b1 || obs_a[c].sel !== want_sel || obs_a[c].bt !== pat[2*DW-c]
          || obs_a[c].done !== (c == 8 || c == 16))
        $display("FAIL back_to_back cycle %0d: got %b want en=1 bit=%b sel=%0d", c, obs_a[c],
                 pat[2*DW-c], want_sel);
      else n_pass++;
    end
    n_checks++;
    if (obs_a[17].en !== 1'b0) $display("FAIL back_to_back_end: en got %b want 0", obs_a[17].en);
    else n_pass++;
  endtask

  task automatic test_bubble;
    do_reset();
    offer_q.push_back('{data: 8'hC3, chan: 2'd1, delay: 0});
    offer_q.push_back('{data: 8'h96, chan: 2'd3, delay: 7});
    run_stream(0, 22);
    n_checks++;
    if (obs_a[8].done !== 1'b1 || obs_a[9].en !== 1'b0 || obs_a[10].en !== 1'b1
        || obs_a[10].sel !== 2'd3 || obs_a[17].done !== 1'b1)
      $display("FAIL bubble: c8 %b c9 %b c10 %b c17 %b want done, idle, start sel=3, done",
               obs_a[8], obs_a[9], obs_a[10], obs_a[17]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    obs_t o;
    obs_t want;
    want = '{rdy: 1'b1, en: 1'b0, bt: 1'b0, done: 1'b0, sel: 2'd0};
    do_reset();
    offer_q.push_back('{data: 8'hE7, chan: 2'd1, delay: 0});
    offer_q.push_back('{data: 8'h55, chan: 2'd3, delay: 0});
    run_stream(1, 4);
    @(negedge clk);
    sample(1, o);
    n_checks++;
    if (o.en !== 1'b1 || o.rdy !== 1'b0)
      $display("FAIL pre_reset_bit4: got %b want en=1 rdy=0", o);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    sample(1, o);
    n_checks++;
    if (o !== want) $display("FAIL reset_mid_frame: got %b want %b", o, want);
    else n_pass++;
    rst = 1'b0;
    model_sel[0] = 2'd0;
    model_sel[1] = 2'd0;
    run_stream(1, 20);
  endtask

  task automatic test_random;
    int n_words;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      n_words = 40;
      for (int i = 0; i < n_words; i++)
        offer_q.push_back('{data: DW'($urandom), chan: 2'($urandom),
                           delay: ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 12))});
      run_stream(k, 1100);
      n_checks++;
      if (n_accepted !== n_words || offer_q.size() != 0)
        $display("FAIL random_accepted dut%0d: got %0d want %0d", k, n_accepted, n_words);
      else n_pass++;
      offer_q.delete();
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);
    test_reset();
    test_idle();
    test_single_frame();
    test_hold();
    test_back_to_back();
    test_bubble();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/demux_tx_scheduler.md
Name: demux_tx_scheduler

Overview:
- Upstream feeder for the 1-to-4 serial channel demultiplexer.
- Accepts (byte, channel) words on a valid/ready handshake and shifts each word out MSB-first on a single serial bit.
- Holds the demux select at the word's channel for the whole frame, then inserts an optional idle gap.
- A one-entry holding register lets the next word be accepted while the current frame is shifting.

Parameters:
- DATA_W, 8: bits per frame; legal range 2..32.
- GAP_CYCLES, 1: idle cycles inserted after each frame; 0 means back-to-back frames; legal range 0..15.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream word present.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  DATA_W  frame payload; bit DATA_W-1 is sent first.
- in_chan  in  2  destination channel, 0..3.
- ser_bit  out  1  serial data to the demux data input.
- ser_sel  out  2  channel select to the demux select input.
- ser_en  out  1  ser_bit carries a valid payload bit this cycle.
- frame_done  out  1  one-cycle pulse coincident with the last bit of a frame.

Behaviour:
- Reset (rst high at an edge):
  - Next cycle: state IDLE, ser_bit=0, ser_sel=0, ser_en=0, frame_done=0, hold register empty, in_ready=1.
  - A frame in progress is aborted; a held word is discarded.
- Handshake:
  - Transfer occurs at an edge where in_valid=1 and in_ready=1.
  - in_ready = !hold_valid, taken from the registered flag, so it carries no combinational path from in_valid.
  - in_data and in_chan are sampled only at a transfer edge.
- Word routing at a transfer edge:
  - IDLE with hold empty: the word loads the shifter directly; next state is SHIFT.
  - Any other state: the word is written into the hold register.
- States:
  - IDLE: ser_en=0. If hold_valid, load the shifter from hold, clear hold, go to SHIFT. Else if a transfer occurs, load from the input, go to SHIFT.
  - SHIFT: ser_en=1, ser_sel=frame channel, ser_bit=current MSB. The shifter moves left one bit per cycle; the bit counter runs DATA_W-1 down to 0.
  - On the counter-0 cycle, frame_done=1. Next state:
    - GAP when GAP_CYCLES>0;
    - otherwise SHIFT, loading hold, when hold_valid;
    - otherwise IDLE.
  - GAP: ser_en=0 for exactly GAP_CYCLES cycles. Then SHIFT, loading hold, when hold_valid; otherwise IDLE.
- Output rules:
  - Outputs are registered; the first bit appears the cycle after the load edge.
  - Whenever ser_en=0, ser_bit=0, so every demux output reads 0.
  - ser_sel keeps the last frame's channel through GAP and IDLE (0 after reset); it changes only at a shifter load.
- Latency: a word accepted in IDLE with hold empty produces its first bit 1 cycle later and its last bit DATA_W cycles later.
- Back-to-back, GAP_CYCLES=0: consecutive frames are contiguous; ser_sel changes between the last bit of one frame and the first bit of the next.
- Boundary cases:
  - A transfer in the same cycle as the last bit with hold previously empty is written to hold. The FSM goes to IDLE, then SHIFT, giving one idle bubble. This is required behaviour.
  - Hold is cleared at the same edge it is drained; in_ready rises the following cycle.
  - in_chan is a plain 2-bit field; all four values are valid.

Decomposition:
- Shared package:
  - state enumeration (IDLE, SHIFT, GAP);
  - NUM_CH=4;
  - SEL_W=2;
  - bit-counter width function clog2(DATA_W);
  - gap-counter width of 4 bits.
- Sub-module piso_shifter:
  - parallel-load, left-shift register with bit counter;
  - inputs: load, shift, load_data;
  - outputs: msb, last.
- The FSM and hold register stay in demux_tx_scheduler.

Test Plan:
- DATA_W=8, GAP=1; send 0xA5 to ch2 at edge 0 -> cycles 1..8: ser_en=1, ser_sel=2, ser_bit=1,0,1,0,0,1,0,1; frame_done in cycle 8; cycle 9 ser_en=0, ser_bit=0; then IDLE.
- Send 0x3C to ch1 at edge 0, then 0xFF to ch3 at edge 1 -> second word goes to hold and in_ready=0 in cycles 2..9; gap in cycle 9; cycles 10..17 ser_sel=3, ser_bit all 1; in_ready=1 from cycle 10.
- Third word offered while hold is full -> not accepted until in_ready returns; its data reaches the serial output unchanged after the held frame.
- GAP_CYCLES=0; 0x81 to ch0 then 0x7E to ch2, queued -> 16 contiguous ser_en cycles; ser_sel goes 0 to 2 between bit 8 and bit 9; frame_done at bits 8 and 16.
- rst pulsed during bit 4 of a frame with a word held -> next cycle ser_en=0, ser_sel=0, in_ready=1; the held word never appears on the serial output.
- in_valid held low for 20 cycles after reset -> ser_en=0, ser_bit=0, frame_done=0 throughout.
